logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit; next generation of the team's two-input gate blocks (NAND/NOR/XOR).
- Applies one of eight selectable bitwise operations to two WIDTH-bit operands.
- Output is registered, with result flags and a completed-transfer counter.
- Valid/ready handshake on both sides, so it drops into streaming datapaths with backpressure.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CNT_W, 16, width of the completed-transfer counter (>=1).

Ports:
- clk        input   1        system clock, all state on rising edge
- rst_n      input   1        asynchronous active-low reset
- in_valid   input   1        operand beat valid
- in_ready   output  1        unit can accept a beat this cycle
- a          input   WIDTH    operand A
- b          input   WIDTH    operand B
- op         input   3        operation select, sampled with the beat
- out_valid  output  1        result beat valid
- out_ready  input   1        downstream accepts result
- y          output  WIDTH    result
- zero       output  1        y == 0
- ones       output  1        y == all ones
- parity     output  1        XOR-reduction of y
- xfer_cnt   output  CNT_W    number of completed output transfers

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous, active-low.
  - While rst_n=0: all pipeline valids=0, y=0, zero=0, ones=0, parity=0, xfer_cnt=0.
  - in_ready=1 from the first cycle after reset release. (It is combinational, so it reads 1 during reset too; inputs are ignored while rst_n=0.)
- op encoding:
  - 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A (b ignored), 7 PASS A.
  - All operations are bitwise over WIDTH bits; no carries, no width growth.
- Pipeline: two register stages.
  - S1 captures a, b and op on an input transfer (in_valid & in_ready).
  - S2 captures the computed y and flags when S1 advances.
  - Latency is exactly 2 cycles from input transfer to out_valid=1 when unstalled.
  - Throughput is 1 beat/cycle with out_ready held high.
- Handshake:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = s1_valid & s2_adv.
  - in_ready = !s1_valid | s2_adv (combinational, no dependence on in_valid).
  - out_valid = s2_valid.
  - y and flags are held stable while out_valid=1 & out_ready=0.
  - Once asserted, out_valid does not drop until the beat transfers.
- Stage update rules:
  - S1: input transfer loads S1 and sets s1_valid=1. Else, if s1_adv, s1_valid=0. Else hold.
  - S2: if s1_adv, load S2 and set s2_valid=1. Else, if out_valid & out_ready, s2_valid=0. Else hold.
  - A simultaneous input transfer and S1->S2 advance is legal; both happen in the same edge, with no bubble.
- Flags: computed from the same y that is loaded into S2, and registered with it.
  - WIDTH=1: zero = !y, ones = y.
- Counter: xfer_cnt increments by 1 on each out_valid & out_ready cycle.
  - Wraps from 2^CNT_W-1 to 0.
  - Cleared only by reset.
- Data/valid invariants:
  - Data registers update only when their stage loads; no X propagation on idle.
  - in_valid=0 never changes stored data.
- Reset mid-operation: in-flight beats are discarded, the counter clears, and no spurious out_valid appears after release.

Test Plan:
- WIDTH=8, out_ready=1; send a=0xF0, b=0x3C for op=0..7 back-to-back -> y = 0x30, 0xFC, 0xCF, 0x03, 0xCC, 0x33, 0x0F, 0xF0 on consecutive cycles.
  - First y appears 2 cycles after the first transfer.
  - xfer_cnt reaches 8.
- Flags: a=0xAA, b=0xAA, op=4 -> y=0x00, zero=1, ones=0, parity=0. Then op=5 -> y=0xFF, zero=0, ones=1, parity=0. Then a=0x01, op=7 -> parity=1.
- Backpressure: stream 4 beats with out_ready=0 -> in_ready drops after 2 accepted beats; y holds the first result stably.
  - Then raise out_ready -> all 4 results emerge in order, with no loss or duplication.
- Random valid/ready toggling, 1000 beats, against a reference model -> in-order match and xfer_cnt == 1000 mod 2^CNT_W.
- CNT_W=4: complete 17 transfers -> xfer_cnt wraps 15 -> 0 and ends at 1.
- Assert rst_n=0 asynchronously mid-clock with both stages valid -> out_valid, y, flags and xfer_cnt go to 0 immediately; no output beat follows release until a new input is accepted.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready on both sides.
// Registered result carries zero/ones/parity flags; xfer_cnt counts output transfers.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ones,
  output logic             parity,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic             s1_valid;
  logic             s2_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] y_next;
  logic             s2_adv;
  logic             s1_adv;
  logic             in_xfer;
  logic             out_xfer;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_adv;
  assign in_ready  = !s1_valid || s2_adv;
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign out_xfer  = s2_valid && out_ready;

  always_comb begin
    y_next = '0;
    case (s1_op)
      3'd0:    y_next = s1_a & s1_b;
      3'd1:    y_next = s1_a | s1_b;
      3'd2:    y_next = ~(s1_a & s1_b);
      3'd3:    y_next = ~(s1_a | s1_b);
      3'd4:    y_next = s1_a ^ s1_b;
      3'd5:    y_next = ~(s1_a ^ s1_b);
      3'd6:    y_next = ~s1_a;
      default: y_next = s1_a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_a     <= a;
      s1_b     <= b;
      s1_op    <= op;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Flags derive from y_next so they always match the y they are loaded with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      y        <= '0;
      zero     <= 1'b0;
      ones     <= 1'b0;
      parity   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      y        <= y_next;
      zero     <= ~|y_next;
      ones     <= &y_next;
      parity   <= ^y_next;
    end else if (out_xfer) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (out_xfer) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed sweeps, backpressure, random traffic
// against a queue-based reference model, counter wrap on a CNT_W=4 twin, and async reset.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] op = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] y;
  logic       zero;
  logic       ones;
  logic       parity;
  logic [15:0] xfer_cnt;

  logic       in_ready4;
  logic       out_valid4;
  logic [7:0] y4;
  logic       zero4;
  logic       ones4;
  logic       parity4;
  logic [3:0] xfer_cnt4;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .ones(ones), .parity(parity), .xfer_cnt(xfer_cnt)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .op(op), .out_valid(out_valid4), .out_ready(out_ready),
    .y(y4), .zero(zero4), .ones(ones4), .parity(parity4), .xfer_cnt(xfer_cnt4)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 5 ms");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0] y;
    logic [2:0] flags;
  } exp_t;

  exp_t       q[$];
  logic [7:0] outlog[$];
  logic [2:0] flog[$];
  int         tests = 0;
  int         fails = 0;
  int unsigned exp_cnt = 0;
  int         cyc = 0;
  int         first_in = -1;
  int         first_out = -1;
  bit         acc = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_y = '0;
  logic [2:0] prev_f = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: bit-by-bit evaluation of the operation truth tables.
  function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb, input logic [2:0] mop);
    exp_t e;
    int   cnt = 0;
    for (int i = 0; i < 8; i++) begin
      bit x = ma[i];
      bit z = mb[i];
      bit r;
      case (mop)
        3'd0: r = x && z;
        3'd1: r = x || z;
        3'd2: r = !(x && z);
        3'd3: r = !(x || z);
        3'd4: r = (x != z);
        3'd5: r = (x == z);
        3'd6: r = !x;
        default: r = x;
      endcase
      e.y[i] = r;
      if (r) cnt++;
    end
    e.flags = {cnt == 0, cnt == 8, (cnt % 2) == 1};
    return e;
  endfunction

  // One clock: observe at the falling edge, then return 1 time unit after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    check("in_ready", in_ready, !(q.size() == 2 && !out_ready));
    if (prev_stall) begin
      check("hold_valid", out_valid, 1);
      check("hold_y", y, prev_y);
      check("hold_flags", {zero, ones, parity}, prev_f);
    end
    check("twin_out", {out_valid4, y4, zero4, ones4, parity4, in_ready4},
          {out_valid, y, zero, ones, parity, in_ready});
    check("xfer_cnt", xfer_cnt, exp_cnt[15:0]);
    check("xfer_cnt4", xfer_cnt4, exp_cnt[3:0]);
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        e = q.pop_front();
        check("y", y, e.y);
        check("flags", {zero, ones, parity}, e.flags);
        outlog.push_back(y);
        flog.push_back({zero, ones, parity});
      end
      exp_cnt++;
      if (first_out < 0) first_out = cyc;
    end
    if (acc) begin
      q.push_back(model(a, b, op));
      if (first_in < 0) first_in = cyc;
    end
    prev_stall = out_valid && !out_ready;
    prev_y = y;
    prev_f = {zero, ones, parity};
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] sa, input logic [7:0] sb, input logic [2:0] sop);
    int n = 0;
    in_valid = 1'b1;
    a = sa;
    b = sb;
    op = sop;
    do begin
      cycle();
      n++;
    end while (!acc && n < 100);
    if (!acc) check("send_timeout", acc, 1);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() > 0 && n < 50) begin
      cycle();
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    q.delete();
    outlog.delete();
    flog.delete();
    exp_cnt = 0;
    prev_stall = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] sweep [8];
    logic [7:0] bp_a [4];
    int         sent;
    int         n;
    sweep = '{8'h30, 8'hFC, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'h0F, 8'hF0};
    bp_a  = '{8'h0F, 8'h5A, 8'h81, 8'hE7};

    // Reset values while held in reset.
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_flags", {zero, ones, parity}, 0);
    check("rst_cnt", xfer_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    do_reset();

    // Op sweep, back-to-back.
    first_in = -1;
    first_out = -1;
    cyc = 0;
    for (int i = 0; i < 8; i++) send(8'hF0, 8'h3C, i[2:0]);
    drain();
    check("latency", first_out - first_in, 2);
    check("sweep_count", outlog.size(), 8);
    for (int i = 0; i < 8 && i < outlog.size(); i++)
      check($sformatf("sweep_y%0d", i), outlog[i], sweep[i]);
    check("sweep_cnt", xfer_cnt, 8);

    // Flags.
    outlog.delete();
    flog.delete();
    send(8'hAA, 8'hAA, 3'd4);
    send(8'hAA, 8'hAA, 3'd5);
    send(8'h01, 8'hAA, 3'd7);
    drain();
    check("flag_count", flog.size(), 3);
    if (flog.size() == 3) begin
      check("flags_xor", {outlog[0], flog[0]}, {8'h00, 3'b100});
      check("flags_xnor", {outlog[1], flog[1]}, {8'hFF, 3'b010});
      check("flags_pass", {outlog[2], flog[2]}, {8'h01, 3'b001});
    end

    // Backpressure.
    outlog.delete();
    out_ready = 1'b0;
    send(bp_a[0], 8'hFF, 3'd0);
    send(bp_a[1], 8'hFF, 3'd0);
    in_valid = 1'b1;
    a = bp_a[2];
    repeat (4) cycle();
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_y", y, bp_a[0]);
    out_ready = 1'b1;
    send(bp_a[2], 8'hFF, 3'd0);
    send(bp_a[3], 8'hFF, 3'd0);
    drain();
    check("bp_count", outlog.size(), 4);
    for (int i = 0; i < 4 && i < outlog.size(); i++)
      check($sformatf("bp_y%0d", i), outlog[i], bp_a[i]);

    // Random traffic, 1000 beats.
    do_reset();
    sent = 0;
    n = 0;
    while (sent < 1000 && n < 20000) begin
      in_valid  = ($urandom_range(3) != 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      op        = 3'($urandom);
      out_ready = ($urandom_range(2) != 0);
      cycle();
      if (acc) sent++;
      n++;
    end
    check("rand_sent", sent, 1000);
    drain();
    check("rand_cnt", xfer_cnt, 16'd1000);
    check("rand_cnt4", xfer_cnt4, 4'd8);

    // Counter wrap on the CNT_W=4 twin.
    do_reset();
    for (int i = 0; i < 17; i++) send(8'(i), 8'h0F, 3'd4);
    drain();
    check("wrap_cnt4", xfer_cnt4, 4'd1);
    check("wrap_cnt16", xfer_cnt, 16'd17);

    // Asynchronous reset mid-clock with both stages full.
    out_ready = 1'b0;
    send(8'h7E, 8'h00, 3'd7);
    send(8'h3C, 8'h00, 3'd7);
    in_valid = 1'b0;
    #1;
    check("pre_rst_full", {out_valid, in_ready}, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_y", y, 0);
    check("arst_flags", {zero, ones, parity}, 0);
    check("arst_cnt", xfer_cnt, 0);
    check("arst_cnt4", xfer_cnt4, 0);
    q.delete();
    outlog.delete();
    exp_cnt = 0;
    prev_stall = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check($sformatf("post_rst_idle%0d", i), out_valid, 0);
    end
    send(8'hC3, 8'h0F, 3'd1);
    drain();
    check("post_rst_count", outlog.size(), 1);
    if (outlog.size() == 1) check("post_rst_y", outlog[0], 8'hCF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
